id_ex_forward: RTL

- ID/EX pipeline register for the 5-stage MIPS core, with EX-stage operand forwarding and load-use hazard detection.
- Captures decoded operands and controls from ID each cycle.
- Resolves RAW hazards against EX/MEM and MEM/WB results.
- Drives the ALU operand inputs `in1` and `in2` and the 4-bit `ALUControl` directly.

---
 rtl/id_ex_forward.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/id_ex_forward.sv
// -----------------------------------------------------------------------------
// id_ex_forward
//
// ID/EX pipeline register for the 5-stage MIPS core. It captures the decoded
// operands and controls from ID, resolves RAW hazards for the EX stage by
// forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
//
// Parameters
//   DW  datapath width
//   RW  register-index width
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   stall             global pipeline freeze: ID/EX holds, flush is ignored
//   flush             turn the incoming ID instruction into a bubble
//   id_*              decoded instruction from ID
//                     id_ctrl = {reg_write, mem_read, mem_write, mem_to_reg}
//   exmem_*, memwb_*  destination/result of the two older instructions
//   load_use_stall    combinational; IF/ID must hold for one cycle
//   alu_in1, alu_in2  forwarded ALU operands
//   alu_ctrl          registered ALU operation code
//   ex_store_data     forwarded rt value (store data for sw)
//   ex_dst, ex_ctrl   registered destination index and control bundle
// -----------------------------------------------------------------------------
module id_ex_forward #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_dst,
    input  logic [3:0]    id_alu_ctrl,
    input  logic          id_alu_src,
    input  logic          id_shift,
    input  logic [3:0]    id_ctrl,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_dst,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_dst,
    input  logic [DW-1:0] memwb_result,
    output logic          load_use_stall,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic [3:0]    ex_ctrl
);

    // Bit position of mem_read inside the control bundle.
    localparam int MEM_READ = 2;

    typedef struct packed {
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dst;
        logic [3:0]    alu_ctrl;
        logic          alu_src;
        logic          shift;
        logic [3:0]    ctrl;
    } ex_regs_t;

    ex_regs_t ex_q;
    ex_regs_t id_d;

    assign id_d = '{
        rs_data:  id_rs_data,
        rt_data:  id_rt_data,
        imm:      id_imm,
        rs:       id_rs,
        rt:       id_rt,
        dst:      id_dst,
        alu_ctrl: id_alu_ctrl,
        alu_src:  id_alu_src,
        shift:    id_shift,
        ctrl:     id_ctrl
    };

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX has no data until MEM, so the
    // dependent instruction in ID waits one cycle and a bubble goes in.
    // The following cycle picks the load value up from MEM/WB.
    // ------------------------------------------------------------------
    assign load_use_stall = rst_n
                          && ex_q.ctrl[MEM_READ]
                          && (ex_q.dst != '0)
                          && ((ex_q.dst == id_rs) || (ex_q.dst == id_rt));

    // ------------------------------------------------------------------
    // Pipeline register. stall outranks flush: a frozen pipe must not
    // lose the instruction in EX, so the flush source re-asserts later.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (stall) begin
            ex_q <= ex_q;
        end else if (flush || load_use_stall) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding. EX/MEM is the younger producer, so it wins over MEM/WB.
    // Register 0 is hard-wired to zero and is never forwarded.
    // ------------------------------------------------------------------
    logic          exmem_hit_rs, exmem_hit_rt;
    logic          memwb_hit_rs, memwb_hit_rt;
    logic [DW-1:0] fwd_rs, fwd_rt;

    assign exmem_hit_rs = exmem_reg_write && (exmem_dst != '0) && (exmem_dst == ex_q.rs);
    assign exmem_hit_rt = exmem_reg_write && (exmem_dst != '0) && (exmem_dst == ex_q.rt);
    assign memwb_hit_rs = memwb_reg_write && (memwb_dst != '0) && (memwb_dst == ex_q.rs);
    assign memwb_hit_rt = memwb_reg_write && (memwb_dst != '0) && (memwb_dst == ex_q.rt);

    assign fwd_rs = exmem_hit_rs ? exmem_result :
                    memwb_hit_rs ? memwb_result : ex_q.rs_data;
    assign fwd_rt = exmem_hit_rt ? exmem_result :
                    memwb_hit_rt ? memwb_result : ex_q.rt_data;

    // ------------------------------------------------------------------
    // Operand select. Shift-by-shamt takes the value from rt and the
    // amount from the immediate; variable shifts arrive with rs/rt
    // already swapped by ID and go through the normal path.
    // ------------------------------------------------------------------
    // NOTE: every output of an always_comb gets a default first, so no
    // path through the block can leave a value held (no latch).
    always_comb begin
        alu_in1 = fwd_rs;
        alu_in2 = fwd_rt;
        if (ex_q.shift) begin
            alu_in1 = fwd_rt;
            alu_in2 = ex_q.imm;
        end else if (ex_q.alu_src) begin
            alu_in2 = ex_q.imm;
        end
    end

    assign ex_store_data = fwd_rt;
    assign alu_ctrl      = ex_q.alu_ctrl;
    assign ex_dst        = ex_q.dst;
    assign ex_ctrl       = ex_q.ctrl;

endmodule
